// File: rtl/exec_muldiv_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_muldiv_if : op/operand/result bundle for exec_muldiv         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface exec_muldiv_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             flush;
   logic             stallM;
   logic             start;
   logic [2:0]       op;
   logic             setFlags;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic [WIDTH-1:0] accLo;
   logic [WIDTH-1:0] accHi;
   logic [TAG_W-1:0] rdLoIn;
   logic [TAG_W-1:0] rdHiIn;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resultLo;
   logic [WIDTH-1:0] resultHi;
   logic             wrHi;
   logic             flagN;
   logic             flagZ;
   logic             flagWe;
   logic [TAG_W-1:0] rdLoOut;
   logic [TAG_W-1:0] rdHiOut;

   modport master (
      output flush, stallM, start, op, setFlags, srcA, srcB, accLo, accHi, rdLoIn, rdHiIn,
      input  busy, done, resultLo, resultHi, wrHi, flagN, flagZ, flagWe, rdLoOut, rdHiOut
   );

   modport slave (
      input  flush, stallM, start, op, setFlags, srcA, srcB, accLo, accHi, rdLoIn, rdHiIn,
      output busy, done, resultLo, resultHi, wrHi, flagN, flagZ, flagWe, rdLoOut, rdHiOut
   );
endinterface
`default_nettype wire

// File: rtl/exec_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_muldiv : multi-cycle radix-2^R multiply/accumulate, E-stage  |
// | Optional restoring divider enabled by `define MULDIV_DIV_EN       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module exec_muldiv #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 4,
   parameter int TAG_W          = 4
) (
   input  logic         clk,
   input  logic         reset,
   exec_muldiv_if.slave bus
);
   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(N - 1);
`ifdef MULDIV_DIV_EN
   localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH - 1);
`endif

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MLA   = 3'b001;
   localparam logic [2:0] OP_UMULL = 3'b010;
   localparam logic [2:0] OP_SMULL = 3'b011;
   localparam logic [2:0] OP_UMLAL = 3'b100;
   localparam logic [2:0] OP_SMLAL = 3'b101;
   localparam logic [2:0] OP_SDIV  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic                 flag_en_q, flag_en_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TAG_W-1:0]     rd_lo_q, rd_lo_d;
   logic [TAG_W-1:0]     rd_hi_q, rd_hi_d;
   logic [WIDTH-1:0]     res_lo_q, res_lo_d;
   logic [WIDTH-1:0]     res_hi_q, res_hi_d;
   logic                 wr_hi_q, wr_hi_d;
   logic                 flag_n_q, flag_n_d;
   logic                 flag_z_q, flag_z_d;
   logic                 done_q, done_d;

   logic                 accept;
   logic                 w_in_signed;
   logic                 w_in_div;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_mac;
   logic [2*WIDTH-1:0]   w_signed;
   logic [2*WIDTH-1:0]   w_res;
   logic                 w_long;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]       w_trial;
   logic [2*WIDTH-1:0]   w_div_step;
`endif

   // Operand conditioning and per-state arithmetic
   always_comb begin
      w_in_signed = (bus.op == OP_SMULL) || (bus.op == OP_SMLAL) || (bus.op == OP_SDIV);
      w_in_div    = (bus.op[2:1] == 2'b11);
      w_a_mag     = (w_in_signed && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
      w_b_mag     = (w_in_signed && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;

      w_mac = prod_q + mcand_q * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};

`ifdef MULDIV_DIV_EN
      // Upper WIDTH+1 bits are the partial remainder already shifted left by one
      w_trial = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplier_q};
      if (!w_trial[WIDTH]) begin
         w_div_step = {w_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end else begin
         w_div_step = {prod_q[2*WIDTH-2:0], 1'b0};
      end
`endif

      w_signed = neg_q ? -prod_q : prod_q;
      w_long   = (op_q == OP_UMULL) || (op_q == OP_SMULL) ||
                 (op_q == OP_UMLAL) || (op_q == OP_SMLAL);
      case (op_q)
         OP_MUL:             w_res = {{WIDTH{1'b0}}, w_signed[WIDTH-1:0]};
         OP_MLA:             w_res = {{WIDTH{1'b0}}, w_signed[WIDTH-1:0] + acc_q[WIDTH-1:0]};
         OP_UMULL, OP_SMULL: w_res = w_signed;
         OP_UMLAL, OP_SMLAL: w_res = w_signed + acc_q;
         default: begin
`ifdef MULDIV_DIV_EN
            w_res = (mplier_q == '0) ? '0 : {{WIDTH{1'b0}}, w_signed[WIDTH-1:0]};
`else
            w_res = '0;
`endif
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      flag_en_d = flag_en_q;
      neg_d     = neg_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      rd_lo_d   = rd_lo_q;
      rd_hi_d   = rd_hi_q;
      res_lo_d  = res_lo_q;
      res_hi_d  = res_hi_q;
      wr_hi_d   = wr_hi_q;
      flag_n_d  = flag_n_q;
      flag_z_d  = flag_z_q;
      done_d    = done_q;
      accept    = 1'b0;

      case (state_q)
         S_IDLE: accept = bus.start;
         S_CALC: begin
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
            prod_d   = w_mac;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
`ifdef MULDIV_DIV_EN
            if (op_q[2:1] == 2'b11) begin
               prod_d   = w_div_step;
               mcand_d  = mcand_q;
               mplier_d = mplier_q;
            end
`endif
         end
         S_FIX: begin
            res_lo_d = w_res[WIDTH-1:0];
            res_hi_d = w_res[2*WIDTH-1:WIDTH];
            wr_hi_d  = w_long;
            flag_n_d = w_long ? w_res[2*WIDTH-1] : w_res[WIDTH-1];
            flag_z_d = (w_res == '0);
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (!bus.stallM) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
               accept  = bus.start;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         op_d      = bus.op;
         neg_d     = w_in_signed & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
         mcand_d   = {{WIDTH{1'b0}}, w_a_mag};
         mplier_d  = w_b_mag;
         acc_d     = {bus.accHi, bus.accLo};
         rd_lo_d   = bus.rdLoIn;
         rd_hi_d   = bus.rdHiIn;
         prod_d    = '0;
         cnt_d     = CNT_MUL;
         state_d   = S_CALC;
`ifdef MULDIV_DIV_EN
         flag_en_d = bus.setFlags;
         if (w_in_div) begin
            prod_d = {{WIDTH{1'b0}}, w_a_mag};
            cnt_d  = CNT_DIV;
         end
`else
         // Without a divider, divide ops fall straight through to a zero result
         flag_en_d = bus.setFlags & ~w_in_div;
         if (w_in_div) begin
            state_d = S_FIX;
         end
`endif
      end

      if (bus.flush) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         flag_en_q <= 1'b0;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         rd_lo_q   <= '0;
         rd_hi_q   <= '0;
         res_lo_q  <= '0;
         res_hi_q  <= '0;
         wr_hi_q   <= 1'b0;
         flag_n_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         flag_en_q <= flag_en_d;
         neg_q     <= neg_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         rd_lo_q   <= rd_lo_d;
         rd_hi_q   <= rd_hi_d;
         res_lo_q  <= res_lo_d;
         res_hi_q  <= res_hi_d;
         wr_hi_q   <= wr_hi_d;
         flag_n_q  <= flag_n_d;
         flag_z_q  <= flag_z_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy     = (state_q == S_CALC) || (state_q == S_FIX) ||
                         ((state_q == S_DONE) && bus.stallM);
   assign bus.done     = done_q;
   assign bus.resultLo = res_lo_q;
   assign bus.resultHi = res_hi_q;
   assign bus.wrHi     = wr_hi_q;
   assign bus.flagN    = flag_n_q;
   assign bus.flagZ    = flag_z_q;
   assign bus.flagWe   = done_q & flag_en_q;
   assign bus.rdLoOut  = rd_lo_q;
   assign bus.rdHiOut  = rd_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_exec_muldiv : directed + random checks against an arithmetic   |
// | reference model. Rev 1.0                                          |
// +------------------------------------------------------------------+
module tb_exec_muldiv;
   localparam int WIDTH = 32;
   localparam int BPC   = 4;
   localparam int TAG_W = 4;
   localparam int N     = WIDTH / BPC;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   exec_muldiv_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   exec_muldiv #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BPC),
      .TAG_W          (TAG_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Expected values for the most recently issued op
   logic [31:0] e_lo, e_hi;
   logic        e_wr, e_n, e_z, e_we;
   logic [3:0]  e_tl, e_th;
   int          e_lat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Edges after the start edge until done is visible: CALC cycles + FIX
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, b, lo, hi, input logic sf);
      logic [63:0] full;
      logic [31:0] r32;
      longint      qs;
      full  = '0;
      r32   = '0;
      e_wr  = 1'b0;
      e_we  = sf;
      e_lat = N + 1;
      case (op)
         3'd0: r32 = a * b;
         3'd1: r32 = a * b + lo;
         3'd2: full = {32'h0, a} * {32'h0, b};
         3'd3: full = 64'(longint'($signed(a)) * longint'($signed(b)));
         3'd4: full = {32'h0, a} * {32'h0, b} + {hi, lo};
         3'd5: full = 64'(longint'($signed(a)) * longint'($signed(b))) + {hi, lo};
         default: begin
`ifdef MULDIV_DIV_EN
            e_lat = WIDTH + 1;
            if (b == 32'h0) begin
               r32 = 32'h0;
            end else if (op == 3'd6) begin
               r32 = a / b;
            end else begin
               qs  = longint'($signed(a)) / longint'($signed(b));
               r32 = 32'(qs);
            end
`else
            e_lat = 1;
            e_we  = 1'b0;
            r32   = 32'h0;
`endif
         end
      endcase
      if (op inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
         e_wr = 1'b1;
         e_lo = full[31:0];
         e_hi = full[63:32];
         e_n  = full[63];
         e_z  = (full == 64'h0);
      end else begin
         e_lo = r32;
         e_hi = 32'h0;
         e_n  = r32[31];
         e_z  = (r32 == 32'h0);
      end
   endtask

   task automatic drive_start(input logic [2:0] op, input logic [31:0] a, b, lo, hi,
                              input logic sf, input logic [3:0] tl, th);
      bus.op       = op;
      bus.srcA     = a;
      bus.srcB     = b;
      bus.accLo    = lo;
      bus.accHi    = hi;
      bus.setFlags = sf;
      bus.rdLoIn   = tl;
      bus.rdHiIn   = th;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge where done is first seen
   task automatic issue(input logic [2:0] op, input logic [31:0] a, b, lo, hi,
                        input logic sf, input logic [3:0] tl, th);
      int k;
      model_op(op, a, b, lo, hi, sf);
      e_tl = tl;
      e_th = th;
      drive_start(op, a, b, lo, hi, sf, tl, th);
      check("busy_after_start", bus.busy, 1);
      k = 0;
      while (!bus.done && k < 100) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("latency op%0d", op), k, e_lat);
      check($sformatf("resultLo op%0d", op), bus.resultLo, e_lo);
      if (e_wr) check($sformatf("resultHi op%0d", op), bus.resultHi, e_hi);
      check("wrHi", bus.wrHi, e_wr);
      check("flagWe", bus.flagWe, e_we);
      if (e_we) begin
         check("flagN", bus.flagN, e_n);
         check("flagZ", bus.flagZ, e_z);
      end
      check("rdLoOut", bus.rdLoOut, e_tl);
      check("rdHiOut", bus.rdHiOut, e_th);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic saw_done;
      int   hold;
      bus.flush    = 1'b0;
      bus.stallM   = 1'b0;
      bus.start    = 1'b0;
      bus.op       = '0;
      bus.setFlags = 1'b0;
      bus.srcA     = '0;
      bus.srcB     = '0;
      bus.accLo    = '0;
      bus.accHi    = '0;
      bus.rdLoIn   = '0;
      bus.rdHiIn   = '0;

      repeat (3) @(negedge clk);
      check("reset_done", bus.done, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_resultLo", bus.resultLo, 0);
      check("reset_flagWe", bus.flagWe, 0);
      reset = 1'b1;
      @(negedge clk);

      issue(3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 4'd1, 4'd2);
      check("mul_42", bus.resultLo, 32'd42);
      @(negedge clk);
      check("mul_done_drop", bus.done, 0);
      check("mul_busy_idle", bus.busy, 0);

      issue(3'd3, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 1'b1, 4'd3, 4'd4);
      check("smull_hi", bus.resultHi, 32'hFFFF_FFFF);
      check("smull_lo", bus.resultLo, 32'hFFFF_FFFA);

      // Back-to-back issue straight from DONE
      issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 4'd5, 4'd6);
      check("umlal_full", {bus.resultHi, bus.resultLo}, 64'hFFFF_FFFF_0000_0002);
      bus.stallM = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_done", bus.done, 1);
         check("stall_busy", bus.busy, 1);
         check("stall_lo", bus.resultLo, 32'h0000_0002);
      end
      bus.stallM = 1'b0;
      issue(3'd1, 32'd5, 32'd5, 32'hFFFF_FFE7, 32'd0, 1'b1, 4'd7, 4'd8);
      check("mla_zero", bus.flagZ, 1);

      // Flush mid-CALC, together with a competing start
      @(negedge clk);
      drive_start(3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 4'd1, 4'd1);
      repeat (3) @(negedge clk);
      bus.flush = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check("flush_busy", bus.busy, 0);
      check("flush_done", bus.done, 0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         saw_done |= bus.done;
      end
      check("flush_no_done", saw_done, 0);

      issue(3'd3, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 4'd9, 4'd10);
      check("smull_min", {bus.resultHi, bus.resultLo}, 64'h4000_0000_0000_0000);

      // Reset pulse during CALC
      drive_start(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 4'd15, 4'd15);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_mid_outputs",
            {bus.done, bus.busy, bus.wrHi, bus.flagN, bus.flagZ, bus.flagWe,
             bus.rdLoOut, bus.rdHiOut}, 0);
      check("rst_mid_result", {bus.resultHi, bus.resultLo}, 0);
      repeat (2) @(negedge clk);
      issue(3'd5, 32'hFFFF_FFFF, 32'd2, 32'd10, 32'd0, 1'b1, 4'd2, 4'd3);

`ifdef MULDIV_DIV_EN
      issue(3'd7, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b1, 4'd1, 4'd0);
      check("sdiv_m7_2", bus.resultLo, 32'hFFFF_FFFD);
      issue(3'd6, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1, 4'd1, 4'd0);
      check("udiv_by0", bus.resultLo, 32'd0);
      issue(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 4'd1, 4'd0);
      check("sdiv_min", bus.resultLo, 32'h8000_0000);
`else
      issue(3'd6, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 4'd1, 4'd0);
      check("nodiv_zero", bus.resultLo, 32'd0);
`endif

      for (int i = 0; i < 40; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick(), pick(), pick(),
               1'($urandom_range(0, 1)), 4'($urandom()), 4'($urandom()));
         hold = $urandom_range(0, 3);
         if (hold > 0) begin
            bus.stallM = 1'b1;
            repeat (hold) begin
               @(negedge clk);
               check("rnd_hold_done", bus.done, 1);
               check("rnd_hold_lo", bus.resultLo, e_lo);
            end
            bus.stallM = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("rnd_done_drop", bus.done, 0);
            check("rnd_busy_idle", bus.busy, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
